// File: rtl/bp_be_dcache_pkg.sv
// Shared dcache opcode and packet types, plus the trace-word field layout used
// by the trace scheduler and by any bench that builds trace words.
package bp_be_dcache_pkg;

  localparam int dcache_opcode_width_gp = 4;

  typedef enum logic [3:0] {
    e_dcache_op_lb  = 4'd0,
    e_dcache_op_lh  = 4'd1,
    e_dcache_op_lw  = 4'd2,
    e_dcache_op_ld  = 4'd3,
    e_dcache_op_lbu = 4'd4,
    e_dcache_op_lhu = 4'd5,
    e_dcache_op_lwu = 4'd6,
    e_dcache_op_sb  = 4'd8,
    e_dcache_op_sh  = 4'd9,
    e_dcache_op_sw  = 4'd10,
    e_dcache_op_sd  = 4'd11
  } bp_be_dcache_opcode_e;

  // Default-width packet; other widths use the same {opcode, page_offset, data} order.
  typedef struct packed {
    bp_be_dcache_opcode_e opcode;
    logic [11:0]          page_offset;
    logic [63:0]          data;
  } bp_be_dcache_pkt_s;

  function automatic int trace_data_lsb();
    return 0;
  endfunction

  function automatic int trace_page_offset_lsb(input int dword_width);
    return dword_width;
  endfunction

  function automatic int trace_ptag_lsb(input int dword_width, input int page_offset_width);
    return dword_width + page_offset_width;
  endfunction

  function automatic int trace_opcode_lsb(input int dword_width, input int paddr_width);
    return dword_width + paddr_width;
  endfunction

endpackage

// File: rtl/bp_be_trace_sched_id_fifo.sv
// Small in-order FIFO holding the requester index of each outstanding dcache
// packet; depth must be a power of two (>= 2) so the pointers wrap naturally.
module bp_be_trace_sched_id_fifo #(
  parameter int depth_p = 4,
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int ptr_width_lp   = $clog2(depth_p);
  localparam int count_width_lp = $clog2(depth_p + 1);
  localparam logic [count_width_lp-1:0] depth_lp = count_width_lp'(depth_p);

  logic [width_p-1:0]        mem_r [depth_p];
  logic [ptr_width_lp-1:0]   wptr_r, rptr_r;
  logic [count_width_lp-1:0] count_r;
  logic                      push_ok, pop_ok;

  assign empty_o = (count_r == '0);
  assign full_o  = (count_r == depth_lp);
  assign pop_ok  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot a push at full needs.
  assign push_ok = push_i & (~full_o | pop_ok);
  assign data_o  = mem_r[rptr_r];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_r[wptr_r] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_ok) wptr_r <= wptr_r + 1'b1;
      if (pop_ok)  rptr_r <= rptr_r + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/bp_be_dcache_trace_sched.sv
// Round-robin scheduler sharing one dcache request port among trace-replay
// sources, with credit limiting, in-order response routing, completion and stall tracking.
module bp_be_dcache_trace_sched
  import bp_be_dcache_pkg::*;
#(
  parameter int num_req_p           = 2,
  parameter int dword_width_p       = 64,
  parameter int paddr_width_p       = 40,
  parameter int page_offset_width_p = 12,
  parameter int ring_width_p        = dword_width_p + paddr_width_p + 4,
  parameter int max_outstanding_p   = 4,
  parameter int watchdog_cycles_p   = 1000000
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
  input  logic [num_req_p-1:0]                      req_v_i,
  input  logic [num_req_p*ring_width_p-1:0]         req_data_i,
  output logic [num_req_p-1:0]                      req_yumi_o,
  input  logic [num_req_p*32-1:0]                   target_count_i,
  input  logic                                      dcache_pkt_ready_i,
  output logic                                      dcache_pkt_v_o,
  output logic [4+page_offset_width_p+dword_width_p-1:0] dcache_pkt_o,
  output logic [paddr_width_p-page_offset_width_p-1:0]   ptag_o,
  input  logic                                      dcache_v_i,
  input  logic [dword_width_p-1:0]                  dcache_data_i,
  output logic [num_req_p-1:0]                      resp_v_o,
  output logic [dword_width_p-1:0]                  resp_data_o,
  output logic [num_req_p-1:0]                      done_o,
  output logic                                      all_done_o,
  output logic                                      stall_o,
  output logic                                      err_o
);

  localparam int id_width_lp        = $clog2(num_req_p);
  localparam int ptag_width_lp      = paddr_width_p - page_offset_width_p;
  localparam int cnt_width_lp       = $clog2(max_outstanding_p + 1);
  localparam int wd_width_lp        = $clog2(watchdog_cycles_p + 1);
  localparam int opcode_lsb_lp      = trace_opcode_lsb(dword_width_p, paddr_width_p);
  localparam int ptag_lsb_lp        = trace_ptag_lsb(dword_width_p, page_offset_width_p);
  localparam int page_offset_lsb_lp = trace_page_offset_lsb(dword_width_p);
  localparam int data_lsb_lp        = trace_data_lsb();
  localparam logic [cnt_width_lp-1:0] max_out_lp  = cnt_width_lp'(max_outstanding_p);
  localparam logic [wd_width_lp-1:0]  wd_limit_lp = wd_width_lp'(watchdog_cycles_p);

  function automatic logic [id_width_lp-1:0] wrap_id(input logic [id_width_lp-1:0] base,
                                                     input int offset);
    return id_width_lp'((int'(base) + offset) % num_req_p);
  endfunction

  // Reset asserts immediately but releases through two flops; everything else keys off 'active'.
  logic [1:0] rst_sync_r;
  logic       active;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rst_sync_r <= '0;
    else            rst_sync_r <= {rst_sync_r[0], 1'b1};
  end

  assign active = rst_sync_r[1];

  logic [id_width_lp-1:0]   last_grant_r, start_id, rot_sel, grant_id, fifo_head;
  logic [num_req_p-1:0]     req_rot;
  logic [cnt_width_lp-1:0]  outstanding_r;
  logic [wd_width_lp-1:0]   wd_cnt_r, wd_cnt_next;
  logic [ring_width_p-1:0]  grant_word;
  logic [31:0]              resp_cnt_r [num_req_p];
  bp_be_dcache_opcode_e     opcode;
  logic credit_ok, issue, pop_v, fifo_full, fifo_empty, busy, late_resp, stall_r, err_r;

  // Rotate so the search starts after the last grant, take the lowest set bit, rotate back.
  always_comb begin
    start_id = wrap_id(last_grant_r, 1);
    req_rot  = '0;
    for (int i = 0; i < num_req_p; i++) req_rot[i] = req_v_i[wrap_id(start_id, i)];
    rot_sel = '0;
    for (int i = num_req_p - 1; i >= 0; i--) if (req_rot[i]) rot_sel = id_width_lp'(i);
    grant_id = wrap_id(rot_sel, int'(start_id));
  end

  assign credit_ok      = (outstanding_r < max_out_lp);
  assign issue          = active & dcache_pkt_ready_i & credit_ok & (|req_v_i);
  assign dcache_pkt_v_o = issue;

  always_comb begin
    req_yumi_o = '0;
    if (issue) req_yumi_o[grant_id] = 1'b1;
  end

  assign grant_word   = req_data_i[int'(grant_id) * ring_width_p +: ring_width_p];
  assign opcode       = bp_be_dcache_opcode_e'(grant_word[opcode_lsb_lp +: 4]);
  assign dcache_pkt_o = active ? {opcode, grant_word[page_offset_lsb_lp +: page_offset_width_p],
                                  grant_word[data_lsb_lp +: dword_width_p]} : '0;
  assign ptag_o       = active ? grant_word[ptag_lsb_lp +: ptag_width_lp] : '0;

  bp_be_trace_sched_id_fifo #(
    .depth_p (max_outstanding_p),
    .width_p (id_width_lp)
  ) id_fifo (
    .clk_i     (clk_i),
    .reset_n_i (active),
    .push_i    (issue),
    .data_i    (grant_id),
    .pop_i     (dcache_v_i),
    .data_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign pop_v = dcache_v_i & ~fifo_empty;

  always_comb begin
    resp_v_o = '0;
    if (active && pop_v) resp_v_o[fifo_head] = 1'b1;
  end

  assign resp_data_o = active ? dcache_data_i : '0;

  always_comb begin
    for (int i = 0; i < num_req_p; i++) done_o[i] = (resp_cnt_r[i] == target_count_i[i*32 +: 32]);
  end

  assign all_done_o = &done_o;
  assign late_resp  = |(resp_v_o & done_o);
  assign busy       = (outstanding_r != '0) | (|req_v_i);

  // Watchdog counts only cycles where work is pending but nothing moves.
  always_comb begin
    wd_cnt_next = wd_cnt_r;
    if (issue || dcache_v_i)              wd_cnt_next = '0;
    else if (busy && wd_cnt_r != wd_limit_lp) wd_cnt_next = wd_cnt_r + 1'b1;
  end

  always_ff @(posedge clk_i or negedge active) begin
    if (!active) begin
      last_grant_r  <= id_width_lp'(num_req_p - 1);
      outstanding_r <= '0;
      wd_cnt_r      <= '0;
      stall_r       <= 1'b0;
      err_r         <= 1'b0;
      for (int i = 0; i < num_req_p; i++) resp_cnt_r[i] <= '0;
    end else begin
      if (issue) last_grant_r <= grant_id;
      case ({issue, pop_v})
        2'b10:   outstanding_r <= outstanding_r + 1'b1;
        2'b01:   outstanding_r <= outstanding_r - 1'b1;
        default: outstanding_r <= outstanding_r;
      endcase
      wd_cnt_r <= wd_cnt_next;
      stall_r  <= stall_r | (wd_cnt_next == wd_limit_lp);
      err_r    <= err_r | (dcache_v_i & fifo_empty) | late_resp | (issue & fifo_full);
      for (int i = 0; i < num_req_p; i++)
        if (resp_v_o[i] && !done_o[i]) resp_cnt_r[i] <= resp_cnt_r[i] + 32'd1;
    end
  end

  assign stall_o = stall_r;
  assign err_o   = err_r;

endmodule

// File: tb/tb_bp_be_dcache_trace_sched.sv
// Directed bench for the dcache trace scheduler: reset, alternation, credit,
// completion, stray response, watchdog stall and mid-run reset.
module tb_bp_be_dcache_trace_sched;

  localparam logic [107:0] word0 = {4'd3, 40'h12_3456_7ABC, 64'h1111_2222_3333_4444};
  localparam logic [107:0] word1 = {4'd10, 40'hAB_CDEF_0123, 64'hDEAD_BEEF_CAFE_F00D};
  localparam logic [79:0]  pkt0  = {4'h3, 12'hABC, 64'h1111_2222_3333_4444};
  localparam logic [79:0]  pkt1  = {4'hA, 12'h123, 64'hDEAD_BEEF_CAFE_F00D};
  localparam logic [27:0]  ptag0 = 28'h1234567;
  localparam logic [27:0]  ptag1 = 28'hABCDEF0;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   req_v = '0;
  logic [215:0] req_data = {word1, word0};
  logic [1:0]   yumi;
  logic [63:0]  target = '0;
  logic         ready = 1'b0;
  logic         pkt_v;
  logic [79:0]  pkt;
  logic [27:0]  ptag;
  logic         dcache_v = 1'b0;
  logic [63:0]  dcache_data = '0;
  logic [1:0]   resp_v;
  logic [63:0]  resp_data;
  logic [1:0]   done;
  logic         all_done, stall, err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bp_be_dcache_trace_sched #(.watchdog_cycles_p(16)) dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n),
    .req_v_i            (req_v),
    .req_data_i         (req_data),
    .req_yumi_o         (yumi),
    .target_count_i     (target),
    .dcache_pkt_ready_i (ready),
    .dcache_pkt_v_o     (pkt_v),
    .dcache_pkt_o       (pkt),
    .ptag_o             (ptag),
    .dcache_v_i         (dcache_v),
    .dcache_data_i      (dcache_data),
    .resp_v_o           (resp_v),
    .resp_data_o        (resp_data),
    .done_o             (done),
    .all_done_o         (all_done),
    .stall_o            (stall),
    .err_o              (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] t0, input logic [31:0] t1);
    reset_n = 1'b0; req_v = '0; ready = 1'b0; dcache_v = 1'b0;
    target = {t1, t0};
    step(); step();
    reset_n = 1'b1;
    step(); step();
  endtask

  task automatic test_reset();
    target = {32'd5, 32'd0};
    step(); step();
    req_v = 2'b11; ready = 1'b1; dcache_v = 1'b1; dcache_data = 64'h55;
    #1;
    n_checks++; if (pkt_v !== 1'b0) $display("[TB] FAIL reset_pkt_v: got %0h want 0", pkt_v); else n_pass++;
    n_checks++; if (yumi !== 2'b00) $display("[TB] FAIL reset_yumi: got %0h want 0", yumi); else n_pass++;
    n_checks++; if (resp_v !== 2'b00) $display("[TB] FAIL reset_resp_v: got %0h want 0", resp_v); else n_pass++;
    n_checks++; if (pkt !== 80'h0) $display("[TB] FAIL reset_pkt: got %0h want 0", pkt); else n_pass++;
    n_checks++; if (resp_data !== 64'h0) $display("[TB] FAIL reset_resp_data: got %0h want 0", resp_data); else n_pass++;
    n_checks++; if (done !== 2'b01) $display("[TB] FAIL reset_done: got %0h want 1", done); else n_pass++;
    n_checks++; if (all_done !== 1'b0) $display("[TB] FAIL reset_all_done: got %0h want 0", all_done); else n_pass++;
    n_checks++; if ({stall, err} !== 2'b00) $display("[TB] FAIL reset_stall_err: got %0h want 0", {stall, err}); else n_pass++;
    dcache_v = 1'b0;
    reset_n = 1'b1;
    step();
    n_checks++; if (pkt_v !== 1'b0) $display("[TB] FAIL sync_release1: got %0h want 0", pkt_v); else n_pass++;
    step();
    n_checks++; if (yumi !== 2'b01) $display("[TB] FAIL sync_release2_yumi: got %0h want 1", yumi); else n_pass++;
  endtask

  task automatic test_alternation();
    logic [1:0] exp_yumi, exp_resp;
    do_reset(32'd3, 32'd3);
    ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req_v       = (c < 6) ? 2'b11 : 2'b00;
      dcache_v    = (c >= 2);
      dcache_data = 64'hC0DE_0000_0000_0000 + 64'(c);
      #1;
      exp_yumi = (c >= 6) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
      exp_resp = (c < 2) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
      n_checks++; if (yumi !== exp_yumi) $display("[TB] FAIL alt_yumi c=%0d: got %0h want %0h", c, yumi, exp_yumi); else n_pass++;
      n_checks++; if (resp_v !== exp_resp) $display("[TB] FAIL alt_resp_v c=%0d: got %0h want %0h", c, resp_v, exp_resp); else n_pass++;
      if (c == 0) begin
        n_checks++; if (pkt !== pkt0) $display("[TB] FAIL alt_pkt0: got %0h want %0h", pkt, pkt0); else n_pass++;
        n_checks++; if (ptag !== ptag0) $display("[TB] FAIL alt_ptag0: got %0h want %0h", ptag, ptag0); else n_pass++;
      end
      if (c == 1) begin
        n_checks++; if (pkt !== pkt1) $display("[TB] FAIL alt_pkt1: got %0h want %0h", pkt, pkt1); else n_pass++;
        n_checks++; if (ptag !== ptag1) $display("[TB] FAIL alt_ptag1: got %0h want %0h", ptag, ptag1); else n_pass++;
      end
      if (c == 2) begin
        n_checks++; if (resp_data !== 64'hC0DE_0000_0000_0002) $display("[TB] FAIL alt_resp_data: got %0h want c0de000000000002", resp_data); else n_pass++;
      end
      step();
    end
    dcache_v = 1'b0;
    #1;
    n_checks++; if (all_done !== 1'b1) $display("[TB] FAIL alt_all_done: got %0h want 1", all_done); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("[TB] FAIL alt_err: got %0h want 0", err); else n_pass++;
  endtask

  task automatic test_credit();
    logic [1:0] exp_yumi;
    do_reset(32'd3, 32'd3);
    ready = 1'b1; req_v = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #1;
      exp_yumi = (c == 4) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
      n_checks++; if (yumi !== exp_yumi) $display("[TB] FAIL credit_yumi c=%0d: got %0h want %0h", c, yumi, exp_yumi); else n_pass++;
      step();
    end
    dcache_v = 1'b1;
    #1;
    n_checks++; if (pkt_v !== 1'b0) $display("[TB] FAIL credit_no_bypass: got %0h want 0", pkt_v); else n_pass++;
    n_checks++; if (resp_v !== 2'b01) $display("[TB] FAIL credit_resp_v: got %0h want 1", resp_v); else n_pass++;
    step();
    dcache_v = 1'b0;
    #1;
    n_checks++; if (yumi !== 2'b01) $display("[TB] FAIL credit_reissue: got %0h want 1", yumi); else n_pass++;
  endtask

  task automatic test_completion();
    do_reset(32'd3, 32'd3);
    ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      req_v = 2'b11; step(); step();
      req_v = 2'b00; dcache_v = 1'b1; step();
      #1;
      if (r == 2) begin
        n_checks++; if (done !== 2'b01) $display("[TB] FAIL compl_done_before: got %0h want 1", done); else n_pass++;
        n_checks++; if (all_done !== 1'b0) $display("[TB] FAIL compl_all_done_before: got %0h want 0", all_done); else n_pass++;
      end
      step();
      dcache_v = 1'b0;
    end
    n_checks++; if (done !== 2'b11) $display("[TB] FAIL compl_done: got %0h want 3", done); else n_pass++;
    n_checks++; if (all_done !== 1'b1) $display("[TB] FAIL compl_all_done: got %0h want 1", all_done); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("[TB] FAIL compl_err_clean: got %0h want 0", err); else n_pass++;
    req_v = 2'b01; step();
    req_v = 2'b00; dcache_v = 1'b1;
    #1;
    n_checks++; if (resp_v !== 2'b01) $display("[TB] FAIL compl_extra_resp_v: got %0h want 1", resp_v); else n_pass++;
    step();
    dcache_v = 1'b0;
    n_checks++; if (err !== 1'b1) $display("[TB] FAIL compl_late_err: got %0h want 1", err); else n_pass++;
    n_checks++; if (done !== 2'b11) $display("[TB] FAIL compl_saturate: got %0h want 3", done); else n_pass++;
  endtask

  task automatic test_stray();
    do_reset(32'd3, 32'd3);
    n_checks++; if (err !== 1'b0) $display("[TB] FAIL stray_err_init: got %0h want 0", err); else n_pass++;
    dcache_v = 1'b1;
    #1;
    n_checks++; if (resp_v !== 2'b00) $display("[TB] FAIL stray_resp_v: got %0h want 0", resp_v); else n_pass++;
    step();
    dcache_v = 1'b0;
    n_checks++; if (err !== 1'b1) $display("[TB] FAIL stray_err: got %0h want 1", err); else n_pass++;
    repeat (3) step();
    n_checks++; if (err !== 1'b1) $display("[TB] FAIL stray_err_sticky: got %0h want 1", err); else n_pass++;
  endtask

  task automatic test_stall();
    do_reset(32'd3, 32'd3);
    ready = 1'b1; req_v = 2'b01;
    step();
    req_v = 2'b00;
    repeat (15) step();
    n_checks++; if (stall !== 1'b0) $display("[TB] FAIL stall_early: got %0h want 0", stall); else n_pass++;
    step();
    n_checks++; if (stall !== 1'b1) $display("[TB] FAIL stall_set: got %0h want 1", stall); else n_pass++;
    repeat (5) step();
    n_checks++; if (stall !== 1'b1) $display("[TB] FAIL stall_sticky: got %0h want 1", stall); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    do_reset(32'd3, 32'd3);
    ready = 1'b1; req_v = 2'b11;
    step(); step();
    reset_n = 1'b0; dcache_v = 1'b1; dcache_data = 64'h77;
    #1;
    n_checks++; if ({pkt_v, yumi} !== 3'b000) $display("[TB] FAIL mid_issue_off: got %0h want 0", {pkt_v, yumi}); else n_pass++;
    n_checks++; if (resp_v !== 2'b00) $display("[TB] FAIL mid_resp_v: got %0h want 0", resp_v); else n_pass++;
    n_checks++; if (done !== 2'b00) $display("[TB] FAIL mid_done: got %0h want 0", done); else n_pass++;
    step();
    req_v = 2'b00; dcache_v = 1'b0; reset_n = 1'b1;
    step(); step();
    dcache_v = 1'b1;
    #1;
    n_checks++; if (resp_v !== 2'b00) $display("[TB] FAIL mid_late_resp_v: got %0h want 0", resp_v); else n_pass++;
    step();
    dcache_v = 1'b0;
    n_checks++; if (err !== 1'b1) $display("[TB] FAIL mid_late_err: got %0h want 1", err); else n_pass++;
    req_v = 2'b11;
    #1;
    n_checks++; if (yumi !== 2'b01) $display("[TB] FAIL mid_first_grant: got %0h want 1", yumi); else n_pass++;
    step();
    req_v = 2'b00;
  endtask

  initial begin
    test_reset();
    test_alternation();
    test_credit();
    test_completion();
    test_stray();
    test_stall();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
